// File: rtl/rv_serializer_if.sv
// Handshake bundle between an entry source, the rv_serializer and a beat sink.
// out_last exists only when RV_SERIALIZER_LAST_EN is defined.
interface rv_serializer_if #(
    parameter int ENTRY_WIDTH = 32,
    parameter int BEAT_WIDTH  = 8
);
    localparam int N_BEATS   = ENTRY_WIDTH / BEAT_WIDTH;
    localparam int IDX_WIDTH = (N_BEATS > 2) ? $clog2(N_BEATS) : 1;

    logic                   in_ready;
    logic                   in_valid;
    logic [ENTRY_WIDTH-1:0] in_data;
    logic                   out_ready;
    logic                   out_valid;
    logic [BEAT_WIDTH-1:0]  out_data;
    logic [IDX_WIDTH-1:0]   beat_idx;
`ifdef RV_SERIALIZER_LAST_EN
    logic                   out_last;

    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, beat_idx, out_last);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, beat_idx, out_last);
`else
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, beat_idx);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, beat_idx);
`endif
endinterface

// File: rtl/rv_serializer.sv
// Splits each ENTRY_WIDTH entry into N_BEATS beats, LSB beat first, with no bubble between entries.
// Optional feature macro: RV_SERIALIZER_LAST_EN adds out_last on the final beat of an entry.
module rv_serializer #(
    parameter int ENTRY_WIDTH = 32,
    parameter int BEAT_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    rv_serializer_if.slave bus
);
    localparam int N_BEATS   = ENTRY_WIDTH / BEAT_WIDTH;
    localparam int IDX_WIDTH = (N_BEATS > 2) ? $clog2(N_BEATS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_BEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    generate
        if ((ENTRY_WIDTH % BEAT_WIDTH) != 0 || N_BEATS < 2) begin : g_bad_params
            $error("rv_serializer: ENTRY_WIDTH must be a multiple of BEAT_WIDTH with at least 2 beats");
        end
    endgenerate

    state_e                 state_q, state_d;
    logic [ENTRY_WIDTH-1:0] hold_q, hold_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   last_beat_s;

    assign last_beat_s = (idx_q == LAST_IDX);

    // State, hold register and beat index; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= {ENTRY_WIDTH{1'b0}};
            idx_q   <= {IDX_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: accept in IDLE, advance on beat handshake, reload on last beat
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    hold_d  = bus.in_data;
                    idx_d   = {IDX_WIDTH{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!bus.out_ready) begin
                    state_d = ST_BUSY;
                end else if (!last_beat_s) begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end else if (bus.in_valid) begin
                    // final beat leaves while the next entry loads: no idle cycle
                    hold_d  = bus.in_data;
                    idx_d   = {IDX_WIDTH{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    hold_d  = {ENTRY_WIDTH{1'b0}};
                    idx_d   = {IDX_WIDTH{1'b0}};
                    state_d = ST_IDLE;
                end
            end
            default: begin
                hold_d  = {ENTRY_WIDTH{1'b0}};
                idx_d   = {IDX_WIDTH{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: beat side purely from registers, in_ready the only path from out_ready
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = {BEAT_WIDTH{1'b0}};
        bus.beat_idx  = idx_q;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
            end
            ST_BUSY: begin
                bus.in_ready  = last_beat_s && bus.out_ready;
                bus.out_valid = 1'b1;
                bus.out_data  = BEAT_WIDTH'(hold_q >> (int'(idx_q) * BEAT_WIDTH));
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

`ifdef RV_SERIALIZER_LAST_EN
    assign bus.out_last = (state_q == ST_BUSY) && last_beat_s;
`endif

endmodule

// File: tb/tb_rv_serializer.sv
// Directed bench for rv_serializer: single entry, back-to-back, backpressure, reset mid-entry.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_rv_serializer;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rv_serializer_if #(.ENTRY_WIDTH(32), .BEAT_WIDTH(8)) bus ();

    rv_serializer #(.ENTRY_WIDTH(32), .BEAT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] idx, input logic ir);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        chk({tag, ".out_data"},  {24'd0, bus.out_data},  {24'd0, d});
        chk({tag, ".beat_idx"},  {30'd0, bus.beat_idx},  {30'd0, idx});
        chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, ir});
`ifdef RV_SERIALIZER_LAST_EN
        chk({tag, ".out_last"},  {31'd0, bus.out_last},  {31'd0, v && (idx == 2'd3)});
`endif
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic ordy);
        @(negedge clk);
        rst          = r;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.out_ready = ordy;
        #1;
    endtask

    initial begin
        logic [31:0] word;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b1);

        // single entry, pulsed for one cycle
        drive(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
        chk_out("single.accept", 1'b0, 8'h00, 2'd0, 1'b1);
        word = 32'hDDCCBBAA;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            chk_out($sformatf("single.beat%0d", i), 1'b1, word[8*i +: 8], 2'(i), i == 3);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("single.idle", 1'b0, 8'h00, 2'd0, 1'b1);

        // back-to-back: second entry loads on the last beat of the first
        drive(1'b0, 1'b1, 32'h04030201, 1'b1);
        chk_out("b2b.accept", 1'b0, 8'h00, 2'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, i < 4, (i < 4) ? 32'h08070605 : 32'h0, 1'b1);
            chk_out($sformatf("b2b.beat%0d", i), 1'b1, 8'(i + 1), 2'(i % 4), (i % 4) == 3);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("b2b.idle", 1'b0, 8'h00, 2'd0, 1'b1);

        // backpressure on beat 0xBB for three cycles
        drive(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("bp.beat0", 1'b1, 8'hAA, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h12345678, 1'b0);
            chk_out($sformatf("bp.stall%0d", i), 1'b1, 8'hBB, 2'd1, 1'b0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("bp.release", 1'b1, 8'hBB, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("bp.beat2", 1'b1, 8'hCC, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("bp.beat3", 1'b1, 8'hDD, 2'd3, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("bp.idle", 1'b0, 8'h00, 2'd0, 1'b1);

        // reset after the 0xBB handshake discards the partial entry
        drive(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("rstmid.beat0", 1'b1, 8'hAA, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("rstmid.beat1", 1'b1, 8'hBB, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 32'h44332211, 1'b1);
        chk_out("rstmid.after", 1'b0, 8'h00, 2'd0, 1'b1);
        word = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            chk_out($sformatf("rstmid.beat%0d", i), 1'b1, word[8*i +: 8], 2'(i), i == 3);
        end

        // reset beats a simultaneous accept in IDLE
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("prio.idle", 1'b0, 8'h00, 2'd0, 1'b1);
        drive(1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("prio.after", 1'b0, 8'h00, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rv_serializer.md
RV_SERIALIZER -- requirements
Module: rv_serializer

Interface
REQ-001 SHALL have parameter ENTRY_WIDTH, default 32: width of each consumed entry.
REQ-002 SHALL have parameter BEAT_WIDTH, default 8: width of each emitted beat.
REQ-003 SHALL derive localparam N_BEATS = ENTRY_WIDTH/BEAT_WIDTH and localparam IDX_WIDTH = max(1, $clog2(N_BEATS)).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port in_ready  output  1  high when an entry can be accepted this cycle.
REQ-008 SHALL have port in_valid  input  1  high when upstream (a fifo dequeue side) presents an entry.
REQ-009 SHALL have port in_data  input  ENTRY_WIDTH  the entry offered by upstream.
REQ-010 SHALL have port out_ready  input  1  high when downstream can take a beat.
REQ-011 SHALL have port out_valid  output  1  high when a beat is presented.
REQ-012 SHALL have port out_data  output  BEAT_WIDTH  the current beat.
REQ-013 SHALL have port beat_idx  output  IDX_WIDTH  index of the current beat (debug).

Function
REQ-014 SHALL reject elaboration unless ENTRY_WIDTH is an integer multiple of BEAT_WIDTH and N_BEATS >= 2.
REQ-015 SHALL implement a two-state FSM: IDLE (no entry held) and BUSY (entry held in an ENTRY_WIDTH hold register).
REQ-016 SHALL accept an entry when in_ready && in_valid; out_valid and out_data SHALL only be functions of registered state.
REQ-017 SHALL drive in_ready = 1 in IDLE, and in_ready = (beat_idx == N_BEATS-1) && out_ready in BUSY; this is the only combinational path (out_ready to in_ready).
REQ-018 SHALL, on accept, load the hold register with in_data, set beat_idx to 0 and enter BUSY on the next cycle (one-cycle accept-to-first-beat latency).
REQ-019 SHALL drive out_valid = 1 exactly in BUSY and out_data = hold[beat_idx*BEAT_WIDTH +: BEAT_WIDTH], LSB beat first.
REQ-020 SHALL increment beat_idx by one on each out_valid && out_ready when beat_idx < N_BEATS-1.
REQ-021 SHALL, on handshake of beat N_BEATS-1: if in_valid is high in the same cycle, load the new entry, reset beat_idx to 0 and stay in BUSY (no bubble); otherwise return to IDLE with beat_idx 0.
REQ-022 SHALL hold out_data, beat_idx and out_valid stable while out_valid && !out_ready (no beat dropped or repeated).
REQ-023 SHALL ignore in_data while in_ready is low; in_valid without in_ready SHALL change no state.
REQ-024 SHALL keep out_data = 0 in IDLE.

Reset
REQ-025 SHALL, when rst is high at a rising edge, enter IDLE, clear the hold register and beat_idx, regardless of any in-progress entry; the partial entry is discarded.
REQ-026 SHALL present after reset: in_ready = 1, out_valid = 0, out_data = 0, beat_idx = 0.
REQ-027 SHALL give rst priority over any simultaneous handshake in the same cycle.

Configuration
REQ-028 SHALL, when macro RV_SERIALIZER_LAST_EN is defined, add port out_last  output  1, equal to out_valid && (beat_idx == N_BEATS-1), and 0 after reset.
REQ-029 SHALL, when RV_SERIALIZER_LAST_EN is undefined, omit out_last entirely with all other behaviour unchanged.

Verification
REQ-030 SHALL cover single entry: reset, in_data=0xDDCCBBAA pulsed one cycle, out_ready=1 -> beats 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting one cycle after accept, then out_valid=0, in_ready=1.
REQ-031 SHALL cover back-to-back: in_valid held high with 0x04030201 then 0x08070605, out_ready=1 -> 8 consecutive beats 0x01..0x08 with no idle cycle; in_ready high only in IDLE and on the cycle of beat 0x04.
REQ-032 SHALL cover backpressure: out_ready low for 3 cycles while beat 0xBB is presented -> out_data=0xBB, beat_idx=1 stable all 3 cycles; sequence resumes with 0xCC.
REQ-033 SHALL cover reset mid-entry: rst asserted after beat 0xBB handshake -> next cycle out_valid=0, beat_idx=0, in_ready=1; subsequent entry 0x44332211 emits 0x11 first.
REQ-034 SHALL cover the macro: with RV_SERIALIZER_LAST_EN defined, out_last is high only alongside beat 0xDD in REQ-030; without it the bench compiles and REQ-030 to REQ-033 pass unchanged.
